// File: rtl/i2f_sched.sv
// i2f_sched: round-robin scheduler that shares one i2f converter among
// N_REQ requesters. One request is captured at a time, i2f is started with
// a single-cycle pulse, the bfloat16 fields are collected on i2f's done
// pulse, and they are returned with the requester ID on a valid/ready channel.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid_i / req_ready_o   per-requester handshake (ready one-hot, grant cycle only)
//   req_int_i / req_frac_i      packed operands, requester k at [k*W +: W]
//   i2f_valid_o/int_o/frac_o    start pulse and held operands to i2f
//   i2f_valid_i/man_i/exp_i/sgn_i  done pulse and result from i2f
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_id_o/man_o/exp_o/sgn_o  response payload
//   rsp_err_o                   watchdog expired (result fields 0)
//
// Optional feature: define I2F_SCHED_TIMEOUT_EN to add a WAIT-state watchdog
// of TIMEOUT_CYC cycles. Without it WAIT waits indefinitely and rsp_err_o is 0.
module i2f_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
`ifdef I2F_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*EXP_W-1:0] req_int_i,
    input  logic [N_REQ*MAN_W-1:0] req_frac_i,
    output logic                   i2f_valid_o,
    output logic [EXP_W-1:0]       i2f_int_o,
    output logic [MAN_W-1:0]       i2f_frac_o,
    input  logic                   i2f_valid_i,
    input  logic [MAN_W-1:0]       i2f_man_i,
    input  logic [EXP_W-1:0]       i2f_exp_i,
    input  logic                   i2f_sgn_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [MAN_W-1:0]       rsp_man_o,
    output logic [EXP_W-1:0]       rsp_exp_o,
    output logic                   rsp_sgn_o,
    output logic                   rsp_err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] idx;
    logic            found;

`ifdef I2F_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] wait_cnt;
`endif

    // Round-robin search: first valid requester starting just after 'last'.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = ID_W'((int'(last) + i) % N_REQ);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                grant = idx;
            end else begin
                found = found;
            end
        end
    end

    // Accept is combinational so the requester sees it in the grant cycle itself.
    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && found) begin
            req_ready_o[grant] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

`ifndef I2F_SCHED_TIMEOUT_EN
    assign rsp_err_o = 1'b0;
`endif

    // Scheduler FSM with all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= ID_W'(N_REQ - 1);
            i2f_valid_o <= 1'b0;
            i2f_int_o   <= '0;
            i2f_frac_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_man_o   <= '0;
            rsp_exp_o   <= '0;
            rsp_sgn_o   <= 1'b0;
`ifdef I2F_SCHED_TIMEOUT_EN
            rsp_err_o   <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        i2f_int_o  <= req_int_i[int'(grant)*EXP_W +: EXP_W];
                        i2f_frac_o <= req_frac_i[int'(grant)*MAN_W +: MAN_W];
                        rsp_id_o   <= grant;
                        last       <= grant;
                        state      <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    // Start pulse is high during the first WAIT cycle.
                    i2f_valid_o <= 1'b1;
                    state       <= WAIT;
`ifdef I2F_SCHED_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                end
                WAIT: begin
                    i2f_valid_o <= 1'b0;
                    if (i2f_valid_i) begin
                        // A done pulse beats a simultaneous watchdog expiry.
                        rsp_man_o   <= i2f_man_i;
                        rsp_exp_o   <= i2f_exp_i;
                        rsp_sgn_o   <= i2f_sgn_i;
                        rsp_valid_o <= 1'b1;
`ifdef I2F_SCHED_TIMEOUT_EN
                        rsp_err_o   <= 1'b0;
`endif
                        state       <= RESP;
`ifdef I2F_SCHED_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_man_o   <= '0;
                        rsp_exp_o   <= '0;
                        rsp_sgn_o   <= 1'b0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        state    <= WAIT;
                    end
`else
                    end else begin
                        state <= WAIT;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state <= RESP;
                    end
                end
                default: begin
                    state       <= IDLE;
                    i2f_valid_o <= 1'b0;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2f_sched.sv
// Directed self-checking bench for i2f_sched. The i2f converter is played by
// the bench, which returns hand-chosen result fields on its done pulse.
module tb_i2f_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid_i;
    logic [3:0]  req_ready_o;
    logic [31:0] req_int_i;
    logic [27:0] req_frac_i;
    logic        i2f_valid_o;
    logic [7:0]  i2f_int_o;
    logic [6:0]  i2f_frac_o;
    logic        i2f_valid_i;
    logic [6:0]  i2f_man_i;
    logic [7:0]  i2f_exp_i;
    logic        i2f_sgn_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [1:0]  rsp_id_o;
    logic [6:0]  rsp_man_o;
    logic [7:0]  rsp_exp_o;
    logic        rsp_sgn_o;
    logic        rsp_err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2f_sched #(
        .N_REQ(4), .ID_W(2), .EXP_W(8), .MAN_W(7)
`ifdef I2F_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_int_i(req_int_i), .req_frac_i(req_frac_i),
        .i2f_valid_o(i2f_valid_o), .i2f_int_o(i2f_int_o), .i2f_frac_o(i2f_frac_o),
        .i2f_valid_i(i2f_valid_i), .i2f_man_i(i2f_man_i),
        .i2f_exp_i(i2f_exp_i), .i2f_sgn_i(i2f_sgn_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_man_o(rsp_man_o), .rsp_exp_o(rsp_exp_o),
        .rsp_sgn_o(rsp_sgn_o), .rsp_err_o(rsp_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Bounded wait for the i2f start pulse; a timeout shows up as a failed check.
    task automatic wait_i2f_pulse(input string tag);
        int t = 0;
        while (i2f_valid_o !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk(tag, {31'd0, i2f_valid_o}, 32'd1);
    endtask

    // Act as i2f: one-cycle done pulse carrying the given result.
    task automatic pulse_done(input logic [6:0] man, input logic [7:0] exp, input logic sgn);
        i2f_man_i   = man;
        i2f_exp_i   = exp;
        i2f_sgn_i   = sgn;
        i2f_valid_i = 1'b1;
        tick();
        i2f_valid_i = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [6:0] man,
                           input logic [7:0] exp, input logic sgn, input logic err);
        chk({tag, "_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        chk({tag, "_id"},    {30'd0, rsp_id_o}, {30'd0, id});
        chk({tag, "_man"},   {25'd0, rsp_man_o}, {25'd0, man});
        chk({tag, "_exp"},   {24'd0, rsp_exp_o}, {24'd0, exp});
        chk({tag, "_sgn"},   {31'd0, rsp_sgn_o}, {31'd0, sgn});
        chk({tag, "_err"},   {31'd0, rsp_err_o}, {31'd0, err});
    endtask

    task automatic accept_rsp();
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {28'd0, req_ready_o}, 32'd0);
        chk({tag, "_i2fv"},  {31'd0, i2f_valid_o}, 32'd0);
        chk({tag, "_int"},   {24'd0, i2f_int_o}, 32'd0);
        chk({tag, "_frac"},  {25'd0, i2f_frac_o}, 32'd0);
        chk({tag, "_rspv"},  {31'd0, rsp_valid_o}, 32'd0);
        chk({tag, "_pay"},   {14'd0, rsp_id_o, rsp_man_o, rsp_exp_o, rsp_sgn_o, rsp_err_o}, 32'd0);
    endtask

    logic [1:0] hold_id;
    logic [6:0] hold_man;
    logic [7:0] hold_exp;

    initial begin
        rst = 1'b1;
        req_valid_i = 4'd0;
        req_int_i   = 32'd0;
        req_frac_i  = 28'd0;
        i2f_valid_i = 1'b0;
        i2f_man_i   = 7'd0;
        i2f_exp_i   = 8'd0;
        i2f_sgn_i   = 1'b0;
        rsp_ready_i = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // A done pulse while IDLE must be ignored.
        pulse_done(7'h11, 8'h22, 1'b1);
        tick();
        chk("stray_done", {31'd0, rsp_valid_o}, 32'd0);

        // Single request from requester 2.
        req_valid_i = 4'b0100;
        req_int_i[16 +: 8] = 8'h05;
        req_frac_i[14 +: 7] = 7'h00;
        #1;
        chk("t1_grant", {28'd0, req_ready_o}, 32'h4);
        chk("t1_nopulse0", {31'd0, i2f_valid_o}, 32'd0);
        tick();
        req_valid_i = 4'b0000;
        #1;
        chk("t1_ready_once", {28'd0, req_ready_o}, 32'd0);
        chk("t1_nopulse1", {31'd0, i2f_valid_o}, 32'd0);
        chk("t1_int", {24'd0, i2f_int_o}, 32'h05);
        tick();
        chk("t1_pulse", {31'd0, i2f_valid_o}, 32'd1);
        tick();
        chk("t1_pulse_end", {31'd0, i2f_valid_o}, 32'd0);
        chk("t1_int_held", {24'd0, i2f_int_o}, 32'h05);
        pulse_done(7'h20, 8'h81, 1'b0);
        chk_rsp("t1", 2'd2, 7'h20, 8'h81, 1'b0, 1'b0);
        accept_rsp();
        chk("t1_rsp_clear", {31'd0, rsp_valid_o}, 32'd0);

        // Fairness: all four continuously valid, last grant was 2 so order is 3,0,1,2,3,0,1,2.
        for (int k = 0; k < 4; k++) begin
            req_int_i[k*8 +: 8] = 8'(8'h10 + k);
            req_frac_i[k*7 +: 7] = 7'(k);
        end
        req_valid_i = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            int exp_g;
            exp_g = (3 + n) % 4;
            #1;
            chk("fair_grant", {28'd0, req_ready_o}, 32'd1 << exp_g);
            tick();
            chk("fair_ready_once", {28'd0, req_ready_o}, 32'd0);
            wait_i2f_pulse("fair_pulse");
            chk("fair_int", {24'd0, i2f_int_o}, 32'h10 + 32'(exp_g));
            chk("fair_frac", {25'd0, i2f_frac_o}, 32'(exp_g));
            pulse_done(7'(n), 8'h80, 1'b0);
            chk("fair_id", {30'd0, rsp_id_o}, 32'(exp_g));
            accept_rsp();
        end
        req_valid_i = 4'b0000;
        tick();

        // Negative input from requester 0 (last grant was 2).
        req_valid_i = 4'b0001;
        req_int_i[0 +: 8] = 8'hFD;
        req_frac_i[0 +: 7] = 7'h00;
        #1;
        chk("neg_grant", {28'd0, req_ready_o}, 32'h1);
        tick();
        req_valid_i = 4'b0000;
        wait_i2f_pulse("neg_pulse");
        chk("neg_int", {24'd0, i2f_int_o}, 32'hFD);
        pulse_done(7'h40, 8'h80, 1'b1);
        chk_rsp("neg", 2'd0, 7'h40, 8'h80, 1'b1, 1'b0);

        // Backpressure: hold the response 10 cycles while requester 1 waits.
        hold_id  = rsp_id_o;
        hold_man = rsp_man_o;
        hold_exp = rsp_exp_o;
        req_valid_i = 4'b0010;
        req_int_i[8 +: 8] = 8'h07;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("bp_fields", {15'd0, rsp_id_o, rsp_man_o, rsp_exp_o},
                {15'd0, hold_id, hold_man, hold_exp});
            chk("bp_noready", {28'd0, req_ready_o}, 32'd0);
            chk("bp_nopulse", {31'd0, i2f_valid_o}, 32'd0);
        end
        accept_rsp();
        #1;
        chk("bp_next_grant", {28'd0, req_ready_o}, 32'h2);

        // Reset in WAIT, two cycles after the start pulse.
        tick();
        req_valid_i = 4'b0000;
        wait_i2f_pulse("rst_pulse");
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        tick();
        rst = 1'b0;
        req_valid_i = 4'b1001;
        #1;
        chk("rst_ptr", {28'd0, req_ready_o}, 32'h1);
        tick();
        req_valid_i = 4'b1000;
        wait_i2f_pulse("rst_pulse2");

`ifdef I2F_SCHED_TIMEOUT_EN
        // Watchdog: no done pulse; expiry after 16 WAIT cycles.
        for (int c = 0; c < 15; c++) tick();
        chk("to_not_yet", {31'd0, rsp_valid_o}, 32'd0);
        tick();
        chk_rsp("to", 2'd0, 7'h00, 8'h00, 1'b0, 1'b1);
        accept_rsp();
        chk("to_clear", {31'd0, rsp_valid_o}, 32'd0);
        #1;
        chk("to_idle_grant", {28'd0, req_ready_o}, 32'h8);
`else
        pulse_done(7'h01, 8'h7F, 1'b0);
        chk_rsp("post_rst", 2'd0, 7'h01, 8'h7F, 1'b0, 1'b0);
        accept_rsp();
        #1;
        chk("post_rst_grant3", {28'd0, req_ready_o}, 32'h8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
